// File: rtl/i2s_rx.sv
// I2S capture receiver: deserializes codec bclk/lr/sdata into signed left/right samples
// with a one-cycle frame strobe in the clk_100 domain. Optional peak meter: `define I2S_RX_PEAK_EN.
module i2s_rx #(
    parameter int unsigned DATA_WIDTH   = 24,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DECAY_FRAMES = 4800
) (
    input  logic                  clk_100,
    input  logic                  reset,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lr,
    input  logic                  i2s_sdata,
    output logic [DATA_WIDTH-1:0] sample_l,
    output logic [DATA_WIDTH-1:0] sample_r,
    output logic                  new_sample,
    output logic                  frame_error
`ifdef I2S_RX_PEAK_EN
    ,
    output logic [3:0]            peak_level
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] WAIT_SYNC = 2'd0;
    localparam logic [1:0] SHIFT     = 2'd1;
    localparam logic [1:0] PAD       = 2'd2;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("i2s_rx: SYNC_STAGES must be at least 2");
    end
    if (DECAY_FRAMES == 0) begin : g_bad_decay
        $error("i2s_rx: DECAY_FRAMES must be nonzero");
    end

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic                   bclk_prev;
    logic                   lr_prev;
    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [CNT_W-1:0]       cnt;
    logic                   ch;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [DATA_WIDTH-1:0]  hold_l;

    logic                   bclk_s_c;
    logic                   lr_s_c;
    logic                   sdata_s_c;
    logic                   rise_c;
    logic                   lr_chg_c;
    logic                   start_c;
    logic                   shift_c;
    logic                   err_c;
    logic                   done_c;
    logic [DATA_WIDTH-1:0]  shreg_next_c;

    // All three pins share the same depth so lr/sdata stay aligned to the bclk edge.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            bclk_sync  <= '0;
            lr_sync    <= '0;
            sdata_sync <= '0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lr_sync    <= {lr_sync[SYNC_STAGES-2:0], i2s_lr};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i2s_sdata};
        end
    end

    assign bclk_s_c     = bclk_sync[SYNC_STAGES-1];
    assign lr_s_c       = lr_sync[SYNC_STAGES-1];
    assign sdata_s_c    = sdata_sync[SYNC_STAGES-1];
    assign rise_c       = bclk_s_c & ~bclk_prev;
    assign lr_chg_c     = lr_s_c != lr_prev;
    assign shreg_next_c = {shreg[DATA_WIDTH-2:0], sdata_s_c};

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // The edge carrying an LR change is the I2S delay slot and is never shifted in.
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        shift_c    = 1'b0;
        err_c      = 1'b0;
        done_c     = 1'b0;
        if (rise_c) begin
            case (state)
                WAIT_SYNC: begin
                    if (lr_chg_c) begin
                        start_c    = 1'b1;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (lr_chg_c) begin
                        err_c   = 1'b1;
                        start_c = 1'b1;
                    end else begin
                        shift_c = 1'b1;
                        if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            done_c     = 1'b1;
                            state_next = PAD;
                        end
                    end
                end
                PAD: begin
                    if (lr_chg_c) begin
                        start_c    = 1'b1;
                        state_next = SHIFT;
                    end
                end
                default: state_next = WAIT_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            bclk_prev   <= 1'b0;
            lr_prev     <= 1'b0;
            cnt         <= '0;
            ch          <= 1'b0;
            shreg       <= '0;
            hold_l      <= '0;
            sample_l    <= '0;
            sample_r    <= '0;
            new_sample  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            new_sample <= 1'b0;
            bclk_prev  <= bclk_s_c;
            if (rise_c) begin
                lr_prev <= lr_s_c;
            end
            if (err_c) begin
                frame_error <= 1'b1;
            end
            if (start_c) begin
                cnt   <= '0;
                ch    <= lr_s_c;
                shreg <= '0;
            end
            if (shift_c) begin
                cnt   <= cnt + CNT_W'(1);
                shreg <= shreg_next_c;
            end
            // A completed right word publishes the frame, reusing the last left word if none arrived.
            if (done_c) begin
                if (!ch) begin
                    hold_l <= shreg_next_c;
                end else begin
                    sample_l   <= hold_l;
                    sample_r   <= shreg_next_c;
                    new_sample <= 1'b1;
                end
            end
        end
    end

`ifdef I2S_RX_PEAK_EN
    localparam int unsigned DECAY_W = $clog2(DECAY_FRAMES + 1);

    // Top four magnitude bits below the sign; the most negative value saturates to full scale.
    function automatic logic [3:0] level_of(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] m;
        if (!x[DATA_WIDTH-1]) begin
            m = x;
        end else if (x[DATA_WIDTH-2:0] == '0) begin
            m = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            m = -x;
        end
        return m[DATA_WIDTH-2 -: 4];
    endfunction

    logic [3:0]         level_l_c;
    logic [3:0]         level_r_c;
    logic [3:0]         level_c;
    logic [DECAY_W-1:0] frame_cnt;

    assign level_l_c = level_of(sample_l);
    assign level_r_c = level_of(sample_r);
    assign level_c   = (level_l_c > level_r_c) ? level_l_c : level_r_c;

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            peak_level <= 4'd0;
            frame_cnt  <= '0;
        end else if (new_sample) begin
            if (level_c > peak_level) begin
                peak_level <= level_c;
                frame_cnt  <= '0;
            end else if (frame_cnt == DECAY_W'(DECAY_FRAMES - 1)) begin
                frame_cnt <= '0;
                if (peak_level != 4'd0) begin
                    peak_level <= peak_level - 4'd1;
                end
            end else begin
                frame_cnt <= frame_cnt + DECAY_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames from the codec side and checks published samples.
// Builds with or without I2S_RX_PEAK_EN.
`timescale 1ns/1ps
module tb_i2s_rx;

    logic        clk_100;
    logic        reset;
    logic        i2s_bclk;
    logic        i2s_lr;
    logic        i2s_sdata;
    logic [23:0] sample_l;
    logic [23:0] sample_r;
    logic        new_sample;
    logic        frame_error;
`ifdef I2S_RX_PEAK_EN
    logic [3:0]  peak_level;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [23:0] ql[$];
    logic [23:0] qr[$];
    longint      qt[$];
    longint      cyc = 0;
    logic        ns_prev = 1'b0;
    int          consec = 0;

    i2s_rx #(
        .DATA_WIDTH (24),
        .SYNC_STAGES(2)
`ifdef I2S_RX_PEAK_EN
        ,
        .DECAY_FRAMES(4)
`endif
    ) dut (
        .clk_100    (clk_100),
        .reset      (reset),
        .i2s_bclk   (i2s_bclk),
        .i2s_lr     (i2s_lr),
        .i2s_sdata  (i2s_sdata),
        .sample_l   (sample_l),
        .sample_r   (sample_r),
        .new_sample (new_sample),
        .frame_error(frame_error)
`ifdef I2S_RX_PEAK_EN
        ,
        .peak_level (peak_level)
`endif
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    // Strobe recorder, sampled on the inactive edge.
    always @(negedge clk_100) begin
        cyc = cyc + 1;
        if (new_sample) begin
            ql.push_back(sample_l);
            qr.push_back(sample_r);
            qt.push_back(cyc);
            if (ns_prev) consec = consec + 1;
        end
        ns_prev = new_sample;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_100);
        #1;
    endtask

    task automatic clear_log();
        ql.delete();
        qr.delete();
        qt.delete();
    endtask

    task automatic send_bit(input logic l, input logic d, input int half);
        i2s_bclk  = 1'b0;
        i2s_lr    = l;
        i2s_sdata = d;
        wait_clk(half);
        i2s_bclk = 1'b1;
        wait_clk(half);
    endtask

    // Edge 0 is the delay slot, edges 1..24 carry the word MSB first, the rest are pad (driven 1).
    task automatic send_half(input logic l, input logic [23:0] w, input int slot, input int half);
        for (int i = 0; i < slot; i++) begin
            logic d;
            d = (i >= 1 && i <= 24) ? w[24 - i] : 1'b1;
            send_bit(l, d, half);
        end
    endtask

    task automatic send_frame(input logic [23:0] l_w, input logic [23:0] r_w, input int slot, input int half);
        send_half(1'b0, l_w, slot, half);
        send_half(1'b1, r_w, slot, half);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        i2s_bclk  = 1'b0;
        i2s_lr    = 1'b0;
        i2s_sdata = 1'b0;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(3);
        clear_log();
    endtask

    // Out of reset lr_prev is 0, so a full right slot is needed to enter slot alignment cleanly.
    task automatic preamble(input int slot);
        send_half(1'b1, 24'h000000, slot, 4);
        wait_clk(20);
        clear_log();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (sample_l !== 24'h0) begin errors++; $display("FAIL reset_sample_l: got %h want 000000", sample_l); end
        vectors++; if (sample_r !== 24'h0) begin errors++; $display("FAIL reset_sample_r: got %h want 000000", sample_r); end
        vectors++; if (new_sample !== 1'b0) begin errors++; $display("FAIL reset_new_sample: got %b want 0", new_sample); end
        vectors++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
`ifdef I2S_RX_PEAK_EN
        vectors++; if (peak_level !== 4'd0) begin errors++; $display("FAIL reset_peak: got %0d want 0", peak_level); end
`endif
    endtask

    task automatic test_nominal();
        do_reset();
        preamble(32);
        send_frame(24'h123456, 24'hABCDEF, 32, 16);
        wait_clk(40);
        vectors++; if (ql.size() !== 1) begin errors++; $display("FAIL nominal_strobes: got %0d want 1", ql.size()); end
        if (ql.size() > 0) begin
            vectors++; if (ql[0] !== 24'h123456) begin errors++; $display("FAIL nominal_left: got %h want 123456", ql[0]); end
            vectors++; if (qr[0] !== 24'hABCDEF) begin errors++; $display("FAIL nominal_right: got %h want abcdef", qr[0]); end
        end
        vectors++; if (frame_error !== 1'b0) begin errors++; $display("FAIL nominal_frame_error: got %b want 0", frame_error); end
        wait_clk(200);
        vectors++; if (sample_l !== 24'h123456) begin errors++; $display("FAIL nominal_hold_left: got %h want 123456", sample_l); end
        vectors++; if (sample_r !== 24'hABCDEF) begin errors++; $display("FAIL nominal_hold_right: got %h want abcdef", sample_r); end
    endtask

    task automatic test_startup();
        do_reset();
        send_half(1'b1, 24'h777777, 10, 4);
        send_frame(24'h800001, 24'h7FFFFE, 32, 4);
        wait_clk(20);
        vectors++; if (ql.size() !== 1) begin errors++; $display("FAIL startup_strobes: got %0d want 1", ql.size()); end
        if (ql.size() > 0) begin
            vectors++; if (ql[0] !== 24'h800001) begin errors++; $display("FAIL startup_left: got %h want 800001", ql[0]); end
            vectors++; if (qr[0] !== 24'h7FFFFE) begin errors++; $display("FAIL startup_right: got %h want 7ffffe", qr[0]); end
        end
    endtask

    task automatic test_short_word();
        do_reset();
        preamble(32);
        send_half(1'b0, 24'h3C3C3C, 11, 4);
        send_half(1'b1, 24'h00F00D, 32, 4);
        vectors++; if (frame_error !== 1'b1) begin errors++; $display("FAIL short_error_set: got %b want 1", frame_error); end
        send_frame(24'h5A5A5A, 24'hA5A5A5, 32, 4);
        wait_clk(20);
        vectors++; if (ql.size() !== 2) begin errors++; $display("FAIL short_strobes: got %0d want 2", ql.size()); end
        if (ql.size() == 2) begin
            vectors++; if (ql[0] !== 24'h000000) begin errors++; $display("FAIL orphan_left: got %h want 000000", ql[0]); end
            vectors++; if (qr[0] !== 24'h00F00D) begin errors++; $display("FAIL orphan_right: got %h want 00f00d", qr[0]); end
            vectors++; if (ql[1] !== 24'h5A5A5A) begin errors++; $display("FAIL short_next_left: got %h want 5a5a5a", ql[1]); end
            vectors++; if (qr[1] !== 24'hA5A5A5) begin errors++; $display("FAIL short_next_right: got %h want a5a5a5", qr[1]); end
        end
        vectors++; if (frame_error !== 1'b1) begin errors++; $display("FAIL short_error_sticky: got %b want 1", frame_error); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_l;
        logic [23:0] exp_r;
        longint      min_gap;
        do_reset();
        preamble(25);
        for (int i = 0; i < 100; i++) begin
            exp_l = 24'(i * 32'h00031415 + 32'h00000100);
            send_frame(exp_l, ~exp_l, 25, 4);
        end
        wait_clk(20);
        vectors++; if (ql.size() !== 100) begin errors++; $display("FAIL tight_strobes: got %0d want 100", ql.size()); end
        if (ql.size() == 100) begin
            for (int i = 0; i < 100; i++) begin
                exp_l = 24'(i * 32'h00031415 + 32'h00000100);
                exp_r = ~exp_l;
                vectors++;
                if (ql[i] !== exp_l || qr[i] !== exp_r) begin
                    errors++;
                    $display("FAIL tight_frame_%0d: got %h/%h want %h/%h", i, ql[i], qr[i], exp_l, exp_r);
                end
            end
            min_gap = 64'd1000000;
            for (int i = 1; i < 100; i++) begin
                if (qt[i] - qt[i-1] < min_gap) min_gap = qt[i] - qt[i-1];
            end
            vectors++; if (min_gap < 384) begin errors++; $display("FAIL tight_spacing: got %0d cycles want >= 384", min_gap); end
        end
        vectors++; if (consec !== 0) begin errors++; $display("FAIL consecutive_strobes: got %0d want 0", consec); end
        vectors++; if (frame_error !== 1'b0) begin errors++; $display("FAIL tight_frame_error: got %b want 0", frame_error); end
    endtask

    task automatic test_reset_mid_word();
        logic [23:0] r2;
        do_reset();
        preamble(32);
        send_frame(24'h135790, 24'h2468AC, 32, 4);
        wait_clk(20);
        vectors++; if (sample_l !== 24'h135790 || sample_r !== 24'h2468AC) begin
            errors++; $display("FAIL midreset_pre: got %h/%h want 135790/2468ac", sample_l, sample_r);
        end
        r2 = 24'hFEDCBA;
        send_half(1'b0, 24'h111111, 32, 4);
        for (int i = 0; i < 12; i++) begin
            send_bit(1'b1, (i >= 1) ? r2[24 - i] : 1'b1, 4);
        end
        i2s_bclk  = 1'b0;
        i2s_lr    = 1'b1;
        i2s_sdata = r2[12];
        wait_clk(2);
        reset = 1'b1;
        #1;
        vectors++; if (sample_l !== 24'h0) begin errors++; $display("FAIL midreset_left: got %h want 000000", sample_l); end
        vectors++; if (sample_r !== 24'h0) begin errors++; $display("FAIL midreset_right: got %h want 000000", sample_r); end
        vectors++; if (new_sample !== 1'b0 || frame_error !== 1'b0) begin
            errors++; $display("FAIL midreset_flags: got %b%b want 00", new_sample, frame_error);
        end
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2);
        clear_log();
        for (int i = 0; i < 13; i++) send_bit(1'b1, 1'b1, 4);
        send_frame(24'h0BEEF0, 24'hC0FFEE, 32, 4);
        wait_clk(20);
        vectors++; if (ql.size() !== 1) begin errors++; $display("FAIL midreset_strobes: got %0d want 1", ql.size()); end
        if (ql.size() > 0) begin
            vectors++; if (ql[0] !== 24'h0BEEF0 || qr[0] !== 24'hC0FFEE) begin
                errors++; $display("FAIL midreset_resume: got %h/%h want 0beef0/c0ffee", ql[0], qr[0]);
            end
        end
    endtask

`ifdef I2S_RX_PEAK_EN
    task automatic test_peak();
        do_reset();
        preamble(25);
        send_frame(24'h7FFFFF, 24'h000000, 25, 4);
        wait_clk(20);
        vectors++; if (peak_level !== 4'd15) begin errors++; $display("FAIL peak_load: got %0d want 15", peak_level); end
        for (int i = 0; i < 4; i++) send_frame(24'h0, 24'h0, 25, 4);
        wait_clk(20);
        vectors++; if (peak_level !== 4'd14) begin errors++; $display("FAIL peak_decay4: got %0d want 14", peak_level); end
        for (int i = 0; i < 4; i++) send_frame(24'h0, 24'h0, 25, 4);
        wait_clk(20);
        vectors++; if (peak_level !== 4'd13) begin errors++; $display("FAIL peak_decay8: got %0d want 13", peak_level); end
        for (int i = 0; i < 52; i++) send_frame(24'h0, 24'h0, 25, 4);
        wait_clk(20);
        vectors++; if (peak_level !== 4'd0) begin errors++; $display("FAIL peak_decay60: got %0d want 0", peak_level); end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        i2s_bclk  = 1'b0;
        i2s_lr    = 1'b0;
        i2s_sdata = 1'b0;
        test_reset();
        test_nominal();
        test_startup();
        test_short_word();
        test_back_to_back();
        test_reset_mid_word();
`ifdef I2S_RX_PEAK_EN
        test_peak();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
Capture-side I2S receiver for the ADAU1761 ADC path. It deserializes the codec's serial data, bit clock and LR clock into signed 24-bit left/right samples, and emits a one-cycle valid strobe per stereo frame in the clk_100 domain. It feeds line-in audio into the echo/ADSR chain and the wave displays, mirroring the existing playback path to the codec.

Parameters:
DATA_WIDTH, 24, bits captured per channel, MSB first; the remaining slot bits are ignored.
SYNC_STAGES, 2, synchronizer depth on i2s_bclk, i2s_lr and i2s_sdata (minimum 2).
DECAY_FRAMES, 4800, frames per peak-meter decay step (used only with I2S_RX_PEAK_EN).

Ports:
clk_100  in  1  system clock, 100 MHz.
reset  in  1  asynchronous, active-high reset.
i2s_bclk  in  1  codec bit clock; asynchronous; at most clk_100/4.
i2s_lr  in  1  codec LR clock; 0 = left, 1 = right; asynchronous.
i2s_sdata  in  1  codec serial data; asynchronous.
sample_l  out  DATA_WIDTH  last complete left sample, two's complement.
sample_r  out  DATA_WIDTH  last complete right sample, two's complement.
new_sample  out  1  one-cycle strobe; sample_l/sample_r updated in the same cycle.
frame_error  out  1  sticky; set on a short channel word.
peak_level  out  4  peak meter; present only with I2S_RX_PEAK_EN.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, all synchronizers 0, FSM = WAIT_SYNC, shift register and bit counter 0.
- Synchronization: all three inputs pass through SYNC_STAGES flops. Rising bclk is detected as the synced value = 1 with the previous synced value = 0. LR and data are sampled from their synced copies in the same cycle as the detection.
- Latency: a pin bclk rise is detected SYNC_STAGES+1 clk_100 cycles later.
- Each detected rising edge: lr_prev <= lr. An LR change is lr != lr_prev.
- FSM, advanced only on detected rising bclk edges:
  - WAIT_SYNC: discard data until the first LR change, then go to SHIFT with cnt = 0 and ch = new lr. The edge with the LR change is the I2S 1-bit delay slot; its data is not captured.
  - SHIFT: shift sdata into the shift register LSB end, cnt++. When cnt reaches DATA_WIDTH: write the word to the ch holding register, then go to PAD.
    - If ch = 1 (right), the completed frame is published in the next clk_100 cycle: sample_l <= held left, sample_r <= new right, new_sample = 1 for exactly one cycle.
  - PAD: ignore bits until an LR change, then go to SHIFT with cnt = 0 and ch = new lr.
- Short word: an LR change while in SHIFT with cnt < DATA_WIDTH sets frame_error, discards the partial word, and restarts SHIFT for the new channel (cnt = 0).
- Orphan channel word: if the right word completes without a left word completed since the last publish, still publish, using the previous left value.
- LR change with no pad: if the LR change lands exactly on the edge after cnt reaches DATA_WIDTH, it is legal (no pad bits).
- new_sample never asserts on two consecutive cycles.
- Outputs hold their values between strobes.
- frame_error clears only on reset.

Optional Feature:
Macro I2S_RX_PEAK_EN.
- Defined: on each new_sample, compute mag = max(|sample_l|, |sample_r|), saturating |-2^23| to 2^23-1.
  - If mag[22:19] > peak_level, peak_level <= mag[22:19].
  - Otherwise, a frame counter decrements peak_level by 1 (floor 0) every DECAY_FRAMES frames. The counter resets on every load.
  - peak_level resets to 0.
- Not defined: the peak_level port, the magnitude logic and the counter are absent. Core behaviour is identical.

Test Plan:
- Nominal frame: bclk = 3.072 MHz, 32-bit slots, left = 24'h123456, right = 24'hABCDEF → exactly one new_sample; sample_l = 24'h123456, sample_r = 24'hABCDEF; frame_error = 0.
- Startup: stream begins mid-right-slot after reset → no new_sample until the first full left+right pair; the first published pair is exact.
- Short word: LR toggles after 10 bits of the left word → frame_error = 1 and stays set; the next full frame still publishes correct values.
- Tight slots: 24-bit slots with no pad, 100 consecutive frames of ramp data → 100 strobes, all values match, and the strobes are spaced by ≥ 48×(bclk period in clk_100 cycles).
- Reset mid-word: assert reset during the 12th right bit → outputs 0 immediately; capture resumes after the next LR change.
- I2S_RX_PEAK_EN: one frame with left = 24'h7FFFFF → peak_level = 15. Then zeros with DECAY_FRAMES = 4 → peak_level = 14 after 4 frames and reaches 0 after 60 frames.
